// File: rtl/exec_mem_pipe_reg.sv
// Execute-to-memory pipeline register with stall/flush control, misaligned
// access trapping and forwarding/load-use hints for the hazard unit.
module exec_mem_pipe_reg #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_stall,
  input  logic                  i_flush,
  input  logic                  i_valid,
  input  logic                  i_reg_we,
  input  logic                  i_mem_we,
  input  logic                  i_mem_re,
  input  logic [1:0]            i_mask_type,
  input  logic                  i_ext_type,
  input  logic [1:0]            i_result_src,
  input  logic [REG_ADDR_W-1:0] i_rd,
  input  logic [XLEN-1:0]       i_alu_result,
  input  logic [XLEN-1:0]       i_write_data,
  input  logic [XLEN-1:0]       i_pc_plus4,
  output logic                  o_valid,
  output logic                  o_reg_we,
  output logic                  o_mem_we,
  output logic [1:0]            o_mask_type,
  output logic                  o_ext_type,
  output logic [1:0]            o_result_src,
  output logic [REG_ADDR_W-1:0] o_rd,
  output logic [XLEN-1:0]       o_alu_result,
  output logic [XLEN-1:0]       o_memory_data,
  output logic [XLEN-1:0]       o_pc_plus4,
  output logic                  o_fwd_en,
  output logic                  o_load_pending,
  output logic                  o_misaligned,
  output logic [XLEN-1:0]       o_bad_addr
);

  localparam logic [1:0] MASK_BYTE = 2'b00;
  localparam logic [1:0] MASK_HALF = 2'b01;
  localparam logic [1:0] SRC_MEM   = 2'b01;

  logic                  misaligned_now;
  logic                  load_en;
  logic                  nxt_valid;
  logic                  nxt_reg_we;
  logic                  nxt_mem_we;
  logic [1:0]            nxt_mask_type;
  logic                  nxt_ext_type;
  logic [1:0]            nxt_result_src;
  logic [REG_ADDR_W-1:0] nxt_rd;
  logic [XLEN-1:0]       nxt_alu_result;
  logic [XLEN-1:0]       nxt_memory_data;
  logic [XLEN-1:0]       nxt_pc_plus4;
  logic                  nxt_misaligned;
  logic [XLEN-1:0]       nxt_bad_addr;

  // Reserved mask encoding is checked with word alignment.
  always_comb begin
    misaligned_now = 1'b0;
    if (i_mem_we | i_mem_re) begin
      case (i_mask_type)
        MASK_BYTE: misaligned_now = 1'b0;
        MASK_HALF: misaligned_now = i_alu_result[0];
        default:   misaligned_now = |i_alu_result[1:0];
      endcase
    end
  end

  always_comb begin
    nxt_valid       = 1'b0;
    nxt_reg_we      = 1'b0;
    nxt_mem_we      = 1'b0;
    nxt_mask_type   = '0;
    nxt_ext_type    = 1'b0;
    nxt_result_src  = '0;
    nxt_rd          = '0;
    nxt_alu_result  = '0;
    nxt_memory_data = '0;
    nxt_pc_plus4    = '0;
    nxt_misaligned  = 1'b0;
    nxt_bad_addr    = '0;
    if (!i_flush && i_valid) begin
      nxt_valid       = 1'b1;
      nxt_reg_we      = i_reg_we & ~misaligned_now;
      nxt_mem_we      = i_mem_we & ~misaligned_now;
      nxt_mask_type   = i_mask_type;
      nxt_ext_type    = i_ext_type;
      nxt_result_src  = i_result_src;
      nxt_rd          = i_rd;
      nxt_alu_result  = i_alu_result;
      nxt_memory_data = i_write_data;
      nxt_pc_plus4    = i_pc_plus4;
      nxt_misaligned  = misaligned_now;
      nxt_bad_addr    = misaligned_now ? i_alu_result : '0;
    end
  end

  // Flush overrides stall; otherwise stall freezes every register.
  assign load_en = i_flush | ~i_stall;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid       <= 1'b0;
      o_reg_we      <= 1'b0;
      o_mem_we      <= 1'b0;
      o_mask_type   <= '0;
      o_ext_type    <= 1'b0;
      o_result_src  <= '0;
      o_rd          <= '0;
      o_alu_result  <= '0;
      o_memory_data <= '0;
      o_pc_plus4    <= '0;
      o_misaligned  <= 1'b0;
      o_bad_addr    <= '0;
    end else if (load_en) begin
      o_valid       <= nxt_valid;
      o_reg_we      <= nxt_reg_we;
      o_mem_we      <= nxt_mem_we;
      o_mask_type   <= nxt_mask_type;
      o_ext_type    <= nxt_ext_type;
      o_result_src  <= nxt_result_src;
      o_rd          <= nxt_rd;
      o_alu_result  <= nxt_alu_result;
      o_memory_data <= nxt_memory_data;
      o_pc_plus4    <= nxt_pc_plus4;
      o_misaligned  <= nxt_misaligned;
      o_bad_addr    <= nxt_bad_addr;
    end
  end

  // Loads are not forwardable from here; rd 0 is never a real dependency.
  assign o_fwd_en       = o_valid & o_reg_we & (o_rd != '0) & (o_result_src != SRC_MEM);
  assign o_load_pending = o_valid & o_reg_we & (o_result_src == SRC_MEM) & (o_rd != '0);

endmodule

// File: tb/tb_exec_mem_pipe_reg.sv
// Bench for exec_mem_pipe_reg: vector table through a one-deep scoreboard
// queue, plus hand sequences for reset behaviour.
module tb_exec_mem_pipe_reg;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_stall = 1'b0, i_flush = 1'b0, i_valid = 1'b0;
  logic        i_reg_we = 1'b0, i_mem_we = 1'b0, i_mem_re = 1'b0;
  logic [1:0]  i_mask_type = '0;
  logic        i_ext_type = 1'b0;
  logic [1:0]  i_result_src = '0;
  logic [4:0]  i_rd = '0;
  logic [31:0] i_alu_result = '0, i_write_data = '0, i_pc_plus4 = '0;
  logic        o_valid, o_reg_we, o_mem_we, o_ext_type, o_fwd_en, o_load_pending, o_misaligned;
  logic [1:0]  o_mask_type, o_result_src;
  logic [4:0]  o_rd;
  logic [31:0] o_alu_result, o_memory_data, o_pc_plus4, o_bad_addr;

  exec_mem_pipe_reg #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_stall(i_stall), .i_flush(i_flush),
    .i_valid(i_valid), .i_reg_we(i_reg_we), .i_mem_we(i_mem_we), .i_mem_re(i_mem_re),
    .i_mask_type(i_mask_type), .i_ext_type(i_ext_type), .i_result_src(i_result_src),
    .i_rd(i_rd), .i_alu_result(i_alu_result), .i_write_data(i_write_data),
    .i_pc_plus4(i_pc_plus4), .o_valid(o_valid), .o_reg_we(o_reg_we), .o_mem_we(o_mem_we),
    .o_mask_type(o_mask_type), .o_ext_type(o_ext_type), .o_result_src(o_result_src),
    .o_rd(o_rd), .o_alu_result(o_alu_result), .o_memory_data(o_memory_data),
    .o_pc_plus4(o_pc_plus4), .o_fwd_en(o_fwd_en), .o_load_pending(o_load_pending),
    .o_misaligned(o_misaligned), .o_bad_addr(o_bad_addr)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic valid, reg_we, mem_we, mem_re;
    logic [1:0] mask;
    logic ext;
    logic [1:0] src;
    logic [4:0] rd;
    logic [31:0] alu, wd, pc;
    logic stall, flush;
  } vin_t;

  typedef struct {
    logic valid, reg_we, mem_we;
    logic [1:0] mask;
    logic ext;
    logic [1:0] src;
    logic [4:0] rd;
    logic [31:0] alu, md, pc;
    logic mis;
    logic [31:0] bad;
    logic fwd, ldp;
  } vexp_t;

  typedef struct {
    vin_t  in;
    vexp_t exp;
  } vec_t;

  vec_t  vecs[$];
  vexp_t sb[$];
  int    errors = 0;
  int    checks = 0;

  function automatic vin_t mk_in(logic valid, logic reg_we, logic mem_we, logic mem_re,
                                 logic [1:0] mask, logic ext, logic [1:0] src, logic [4:0] rd,
                                 logic [31:0] alu, logic [31:0] wd, logic [31:0] pc,
                                 logic stall, logic flush);
    vin_t v;
    v.valid = valid; v.reg_we = reg_we; v.mem_we = mem_we; v.mem_re = mem_re;
    v.mask = mask; v.ext = ext; v.src = src; v.rd = rd;
    v.alu = alu; v.wd = wd; v.pc = pc; v.stall = stall; v.flush = flush;
    return v;
  endfunction

  function automatic vexp_t mk_exp(logic valid, logic reg_we, logic mem_we, logic [1:0] mask,
                                   logic ext, logic [1:0] src, logic [4:0] rd, logic [31:0] alu,
                                   logic [31:0] md, logic [31:0] pc, logic mis, logic [31:0] bad,
                                   logic fwd, logic ldp);
    vexp_t e;
    e.valid = valid; e.reg_we = reg_we; e.mem_we = mem_we; e.mask = mask;
    e.ext = ext; e.src = src; e.rd = rd; e.alu = alu; e.md = md; e.pc = pc;
    e.mis = mis; e.bad = bad; e.fwd = fwd; e.ldp = ldp;
    return e;
  endfunction

  task automatic add(vin_t i, vexp_t e);
    vec_t v;
    v.in = i; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(string nm, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(vin_t v);
    i_valid = v.valid; i_reg_we = v.reg_we; i_mem_we = v.mem_we; i_mem_re = v.mem_re;
    i_mask_type = v.mask; i_ext_type = v.ext; i_result_src = v.src; i_rd = v.rd;
    i_alu_result = v.alu; i_write_data = v.wd; i_pc_plus4 = v.pc;
    i_stall = v.stall; i_flush = v.flush;
  endtask

  task automatic compare_all(int idx, vexp_t e);
    check("valid", idx, {31'b0, o_valid}, {31'b0, e.valid});
    check("reg_we", idx, {31'b0, o_reg_we}, {31'b0, e.reg_we});
    check("mem_we", idx, {31'b0, o_mem_we}, {31'b0, e.mem_we});
    check("mask_type", idx, {30'b0, o_mask_type}, {30'b0, e.mask});
    check("ext_type", idx, {31'b0, o_ext_type}, {31'b0, e.ext});
    check("result_src", idx, {30'b0, o_result_src}, {30'b0, e.src});
    check("rd", idx, {27'b0, o_rd}, {27'b0, e.rd});
    check("alu_result", idx, o_alu_result, e.alu);
    check("memory_data", idx, o_memory_data, e.md);
    check("pc_plus4", idx, o_pc_plus4, e.pc);
    check("misaligned", idx, {31'b0, o_misaligned}, {31'b0, e.mis});
    check("bad_addr", idx, o_bad_addr, e.bad);
    check("fwd_en", idx, {31'b0, o_fwd_en}, {31'b0, e.fwd});
    check("load_pending", idx, {31'b0, o_load_pending}, {31'b0, e.ldp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vexp_t zero_e, e;
    vin_t  idle;
    zero_e = mk_exp(0,0,0,2'd0,0,2'd0,5'd0,32'h0,32'h0,32'h0,0,32'h0,0,0);
    idle   = mk_in(0,0,0,0,2'd0,0,2'd0,5'd0,32'h0,32'h0,32'h0,0,0);

    // word store, then ALU op held across three stalls with changing inputs
    add(mk_in(1,0,1,0,2'b10,0,2'b00,5'd0,32'h100,32'hDEADBEEF,32'h4,0,0),
        mk_exp(1,0,1,2'b10,0,2'b00,5'd0,32'h100,32'hDEADBEEF,32'h4,0,32'h0,0,0));
    add(mk_in(1,1,0,0,2'b10,0,2'b00,5'd5,32'h1234,32'h55,32'h8,0,0),
        mk_exp(1,1,0,2'b10,0,2'b00,5'd5,32'h1234,32'h55,32'h8,0,32'h0,1,0));
    for (int k = 0; k < 3; k++)
      add(mk_in(1,1,0,0,2'b00,1,2'b10,5'd9,32'hAAAA,32'h77,32'hC,1,0),
          mk_exp(1,1,0,2'b10,0,2'b00,5'd5,32'h1234,32'h55,32'h8,0,32'h0,1,0));
    add(mk_in(1,1,0,0,2'b00,1,2'b10,5'd9,32'hAAAA,32'h77,32'hC,0,0),
        mk_exp(1,1,0,2'b00,1,2'b10,5'd9,32'hAAAA,32'h77,32'hC,0,32'h0,1,0));
    // store held by stall, then flush+stall together
    add(mk_in(1,0,1,0,2'b10,0,2'b00,5'd0,32'h200,32'h11,32'h10,0,0),
        mk_exp(1,0,1,2'b10,0,2'b00,5'd0,32'h200,32'h11,32'h10,0,32'h0,0,0));
    add(mk_in(1,0,1,0,2'b10,0,2'b00,5'd0,32'h300,32'h22,32'h14,1,0),
        mk_exp(1,0,1,2'b10,0,2'b00,5'd0,32'h200,32'h11,32'h10,0,32'h0,0,0));
    add(mk_in(1,0,1,0,2'b10,0,2'b00,5'd0,32'h300,32'h22,32'h14,1,1), zero_e);
    // half loads: misaligned then aligned
    add(mk_in(1,1,0,1,2'b01,1,2'b01,5'd7,32'h103,32'h0,32'h18,0,0),
        mk_exp(1,0,0,2'b01,1,2'b01,5'd7,32'h103,32'h0,32'h18,1,32'h103,0,0));
    add(mk_in(1,1,0,1,2'b01,1,2'b01,5'd7,32'h102,32'h0,32'h18,0,0),
        mk_exp(1,1,0,2'b01,1,2'b01,5'd7,32'h102,32'h0,32'h18,0,32'h0,0,1));
    // byte load at odd address, then ALU op to rd 0
    add(mk_in(1,1,0,1,2'b00,0,2'b01,5'd3,32'h1,32'h0,32'h1C,0,0),
        mk_exp(1,1,0,2'b00,0,2'b01,5'd3,32'h1,32'h0,32'h1C,0,32'h0,0,1));
    add(mk_in(1,1,0,0,2'b10,0,2'b00,5'd0,32'h42,32'h0,32'h20,0,0),
        mk_exp(1,1,0,2'b10,0,2'b00,5'd0,32'h42,32'h0,32'h20,0,32'h0,0,0));
    // invalid instruction becomes a bubble
    add(mk_in(0,1,1,1,2'b10,1,2'b01,5'd8,32'h500,32'h66,32'h24,0,0), zero_e);
    // misaligned word store, held through a stall
    add(mk_in(1,0,1,0,2'b10,0,2'b00,5'd0,32'h202,32'h99,32'h28,0,0),
        mk_exp(1,0,0,2'b10,0,2'b00,5'd0,32'h202,32'h99,32'h28,1,32'h202,0,0));
    add(mk_in(1,0,1,0,2'b10,0,2'b00,5'd0,32'h400,32'h1,32'h2C,1,0),
        mk_exp(1,0,0,2'b10,0,2'b00,5'd0,32'h202,32'h99,32'h28,1,32'h202,0,0));
    // reserved mask treated as word
    add(mk_in(1,1,0,1,2'b11,0,2'b01,5'd4,32'h104,32'h0,32'h30,0,0),
        mk_exp(1,1,0,2'b11,0,2'b01,5'd4,32'h104,32'h0,32'h30,0,32'h0,0,1));
    add(mk_in(1,0,1,0,2'b11,0,2'b00,5'd0,32'h106,32'h5,32'h34,0,0),
        mk_exp(1,0,0,2'b11,0,2'b00,5'd0,32'h106,32'h5,32'h34,1,32'h106,0,0));
    // no memory access: odd address with half mask is not misaligned
    add(mk_in(1,1,0,0,2'b01,0,2'b00,5'd8,32'h3,32'h0,32'h38,0,0),
        mk_exp(1,1,0,2'b01,0,2'b00,5'd8,32'h3,32'h0,32'h38,0,32'h0,1,0));
    // aligned half store at bit1 set
    add(mk_in(1,0,1,0,2'b01,0,2'b00,5'd0,32'h2,32'hAB,32'h3C,0,0),
        mk_exp(1,0,1,2'b01,0,2'b00,5'd0,32'h2,32'hAB,32'h3C,0,32'h0,0,0));
    // load to rd 0 is not a pending load
    add(mk_in(1,1,0,1,2'b10,0,2'b01,5'd0,32'h8,32'h0,32'h40,0,0),
        mk_exp(1,1,0,2'b10,0,2'b01,5'd0,32'h8,32'h0,32'h40,0,32'h0,0,0));

    // reset state
    drive(idle);
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    compare_all(-1, zero_e);
    i_rst = 1'b0;

    foreach (vecs[n]) begin
      @(negedge i_clk);
      drive(vecs[n].in);
      sb.push_back(vecs[n].exp);
      @(posedge i_clk);
      #1;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard[%0d]: got empty queue expected one entry", n);
      end else begin
        e = sb.pop_front();
        compare_all(n, e);
      end
    end

    // async reset mid-stall drops the held store before the next edge
    @(negedge i_clk);
    drive(mk_in(1,0,1,0,2'b10,0,2'b00,5'd0,32'h600,32'hCAFE,32'h44,0,0));
    @(posedge i_clk);
    #1;
    check("pre_rst_valid", 100, {31'b0, o_valid}, 32'd1);
    check("pre_rst_mem_we", 100, {31'b0, o_mem_we}, 32'd1);
    i_stall = 1'b1;
    #2;
    i_rst = 1'b1;
    #1;
    compare_all(101, zero_e);
    @(negedge i_clk);
    i_rst = 1'b0;
    drive(idle);
    @(posedge i_clk);
    #1;
    compare_all(102, zero_e);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
